// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//
// Computes a WIDTH-bit sum by driving one external 4-bit adder slice once per
// clock, least-significant nibble first, with the carry chained through an
// internal register. Operands are taken with a valid/ready handshake, and the
// result is offered with a second valid/ready handshake.
//
// Optional feature: define NIBBLE_ADD_SUB_EN to add the op_sub port and
// support A-B (B is inverted and the initial carry is 1). When it is not
// defined, the block only adds.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start_valid/ready  operand handshake (op_a, op_b, op_sub when enabled)
//   nib_a, nib_b       nibble operands sent to the slice (nib_b is already inverted for subtract)
//   nib_cin            carry-in sent to the slice
//   nib_sum, nib_cout  combinational answer from the slice
//   res_valid/ready    result handshake
//   result             WIDTH-bit sum, held until the next operation writes it
//   carry_out          carry out of the top nibble (no-borrow flag for subtract)
//   overflow           two's-complement signed overflow
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b,
  output logic             nib_cin,
  input  logic [3:0]       nib_sum,
  input  logic             nib_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;      // holds B', meaning it is already inverted for subtract
  logic             carry_reg;
  logic [KW-1:0]    k;
  logic             sub_sel;
  logic             last_step;

`ifdef NIBBLE_ADD_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign last_step = (k == KW'(NIB - 1));

  // The slice is combinational. It therefore has to see the current nibble
  // in the same cycle as its answer is captured. For that reason the nibble
  // outputs are a mux from registers and are not registered a second time.
  always_comb begin
    nib_a   = 4'd0;
    nib_b   = 4'd0;
    nib_cin = 1'b0;
    if (state == RUN) begin
      nib_cin = carry_reg;
      for (int i = 0; i < NIB; i++) begin
        if (k == KW'(i)) begin
          nib_a = a_reg[4*i +: 4];
          nib_b = b_reg[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      result      <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      carry_reg   <= 1'b0;
      k           <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start_ready is always 1 in IDLE, so start_valid alone completes the handshake
          if (start_valid) begin
            a_reg       <= op_a;
            b_reg       <= sub_sel ? ~op_b : op_b;
            carry_reg   <= sub_sel;
            k           <= '0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end

        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (k == KW'(i)) begin
              result[4*i +: 4] <= nib_sum;
            end
          end
          carry_reg <= nib_cout;
          if (last_step) begin
            // The top result bit is being written in this cycle, so take it from the slice directly.
            carry_out <= nib_cout;
            overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (nib_sum[3] != a_reg[WIDTH-1]);
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;
`ifdef NIBBLE_ADD_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             op_sub = 1'b0;
  logic [3:0]       nib_a, nib_b, nib_sum;
  logic             nib_cin, nib_cout;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             carry_out, overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural 4-bit adder slice
  assign {nib_cout, nib_sum} = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, nib_cin};

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b),
`ifdef NIBBLE_ADD_SUB_EN
    .op_sub(op_sub),
`endif
    .nib_a(nib_a), .nib_b(nib_b), .nib_cin(nib_cin),
    .nib_sum(nib_sum), .nib_cout(nib_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. The phase is 0 for idle, 1 for busy and 2 for a result offered.
  // The busy phase lasts NIB cycles. The answers come from plain wide arithmetic.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [31:0] m_a = '0, m_bp = '0;
  logic        m_cin0 = 1'b0;
  logic [31:0] h_res = '0;
  logic        h_co = 1'b0, h_ov = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [63:0] sum;
    logic        s;
    if (rst) begin
      m_phase = 0; m_cnt = 0; h_res = '0; h_co = 1'b0; h_ov = 1'b0;
    end else begin
      case (m_phase)
        0: if (start_valid) begin
          s      = HAS_SUB && op_sub;
          m_a    = op_a;
          m_bp   = s ? ~op_b : op_b;
          m_cin0 = s;
          m_cnt  = 0;
          m_phase = 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt == NIB) begin
            sum   = {32'd0, m_a} + {32'd0, m_bp} + {63'd0, m_cin0};
            h_res = sum[31:0];
            h_co  = sum[32];
            h_ov  = (m_a[31] == m_bp[31]) && (h_res[31] != m_a[31]);
            m_phase = 2;
          end
        end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  // The compare process checks every output on every falling edge.
  always @(negedge clk) begin
    logic [63:0] mask, partial;
    check("start_ready", start_ready, m_phase == 0);
    check("res_valid", res_valid, m_phase == 2);
    if (m_phase == 1) begin
      mask    = (64'd1 << (4 * m_cnt)) - 64'd1;
      partial = ({32'd0, m_a} & mask) + ({32'd0, m_bp} & mask) + {63'd0, m_cin0};
      check("nib_a", nib_a, (m_a >> (4 * m_cnt)) & 32'hF);
      check("nib_b", nib_b, (m_bp >> (4 * m_cnt)) & 32'hF);
      check("nib_cin", nib_cin, (partial >> (4 * m_cnt)) & 64'd1);
    end else begin
      check("nib_idle", {nib_a, nib_b, nib_cin}, 0);
      check("result", result, h_res);
      check("carry_out", carry_out, h_co);
      check("overflow", overflow, h_ov);
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input int hold, output logic [31:0] r, output logic co,
                        output logic ov, output int lat);
    int n;
    n = 0;
    while (!start_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!start_ready) check("accept_timeout", 0, 1);
    op_a = a; op_b = b; op_sub = sub; start_valid = 1'b1;
    res_ready = (hold == 0);
    @(posedge clk); #1;                 // accept edge E0
    start_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; op_sub = $urandom_range(0, 1);
    lat = 0;
    while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r = result; co = carry_out; ov = overflow;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        start_valid = 1'b1; op_a = $urandom; op_b = $urandom;
        @(posedge clk); #1;
        check("bp_valid", res_valid, 1);
        check("bp_result", {result, carry_out, overflow}, {r, co, ov});
        check("bp_start_ready", start_ready, 0);
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
    end
    @(posedge clk); #1;                 // result handshake
    res_ready = 1'b0;
    check("post_hs_valid", res_valid, 0);
    check("post_hs_start_ready", start_ready, 1);
  endtask

  initial begin
    logic [31:0] r;
    logic        co, ov;
    int          lat, n;
    logic [31:0] ra, rb;
    logic        rs;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_outputs", {res_valid, result, carry_out, overflow, nib_a, nib_b, nib_cin}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd2, 32'd6, 1'b0, 0, r, co, ov, lat);
    check("add2_6_result", r, 32'd8);
    check("add2_6_flags", {co, ov}, 2'b00);
    check("add2_6_latency", lat, NIB);

    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, r, co, ov, lat);
    check("addFF_1_result", r, 32'd0);
    check("addFF_1_flags", {co, ov}, 2'b10);
    check("addFF_1_latency", lat, NIB);

    // Backpressure for 5 cycles while a concurrent start_valid is shown and must be ignored
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 5, r, co, ov, lat);
    check("add7F_1_result", r, 32'h8000_0000);
    check("add7F_1_flags", {co, ov}, 2'b01);

    // Reset while the nibble index is 3
    n = 0;
    while (!start_ready && n < 50) begin @(posedge clk); #1; n++; end
    op_a = 32'h1234_5678; op_b = 32'h0F0F_0F0F; start_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_start_ready", start_ready, 1);
    check("midrst_outputs", {res_valid, result, carry_out, overflow, nib_a, nib_b, nib_cin}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", res_valid, 0);
    end
    res_ready = 1'b0;
    run_op(32'd3, 32'd1, 1'b0, 0, r, co, ov, lat);
    check("after_rst_3_1", r, 32'd4);

    if (HAS_SUB) begin
      run_op(32'd3, 32'd10, 1'b1, 0, r, co, ov, lat);
      check("sub3_10_result", r, 32'hFFFF_FFF9);
      check("sub3_10_flags", {co, ov}, 2'b00);
      run_op(32'd10, 32'd3, 1'b1, 2, r, co, ov, lat);
      check("sub10_3_result", r, 32'd7);
      check("sub10_3_carry", co, 1'b1);
    end

    for (int t = 0; t < 30; t++) begin
      ra = $urandom;
      rb = $urandom;
      rs = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
      if (t % 5 == 0) ra = {1'b0, ra[30:0]} | 32'h4000_0000;
      run_op(ra, rb, rs, $urandom_range(0, 3), r, co, ov, lat);
      check("rand_latency", lat, NIB);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
